// File: rtl/audio_i2s_serialiser.sv
// audio_i2s_serialiser
// Accepts one stereo sample word per frame through a valid/ready handshake
// into a one-entry holding buffer and shifts it out as a standard I2S stream.
//
// Ports:
//   c         system clock, rising edge
//   r         synchronous active-high reset
//   x         sample word, left = x[31:16], right = x[15:0], MSB first
//   x_valid   x holds a sample
//   x_ready   holding buffer empty (decoded from hold_full)
//   bclk      I2S bit clock
//   lrclk     word select, 0 = left, 1 = right
//   sdata     serial data, changes on bclk falling events only
//   underrun  one-cycle pulse when a frame starts with the buffer empty
module audio_i2s_serialiser #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        c,
  input  logic        r,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic        x_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_W - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(SAMPLE_W / 2);

  logic [DIV_W-1:0]    div_cnt,   div_cnt_nxt;
  logic [IDX_W-1:0]    bit_idx,   bit_idx_nxt;
  logic [SAMPLE_W-1:0] sr,        sr_nxt;
  logic [SAMPLE_W-1:0] hold,      hold_nxt;
  logic                hold_full, hold_full_nxt;
  logic                bclk_nxt;
  logic                lrclk_nxt;
  logic                sdata_nxt;
  logic                underrun_nxt;

  logic             tc;
  logic             fall_evt;
  logic             load_evt;
  logic             xfer;
  logic [IDX_W-1:0] bit_idx_inc;

  // Event decode: divider terminal count, bclk falling event, frame load.
  assign tc          = (div_cnt == DIV_LAST);
  assign fall_evt    = tc && bclk;
  assign load_evt    = fall_evt && (bit_idx == LAST_IDX);
  assign xfer        = x_valid && !hold_full;
  assign bit_idx_inc = bit_idx + IDX_W'(1);

  assign x_ready = !hold_full;

  // Next-state logic for divider, frame position, shifter and holding buffer.
  always_comb begin
    div_cnt_nxt   = div_cnt;
    bclk_nxt      = bclk;
    bit_idx_nxt   = bit_idx;
    sr_nxt        = sr;
    sdata_nxt     = sdata;
    lrclk_nxt     = lrclk;
    underrun_nxt  = 1'b0;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;

    if (tc) begin
      div_cnt_nxt = '0;
      bclk_nxt    = !bclk;
    end else begin
      div_cnt_nxt = div_cnt + DIV_W'(1);
    end

    if (fall_evt) begin
      bit_idx_nxt = bit_idx_inc;
      // Pre-load sr[31] goes out: the previous frame's right LSB sits in slot 0.
      sdata_nxt   = sr[SAMPLE_W-1];
      lrclk_nxt   = (bit_idx_inc >= HALF_IDX);
      if (load_evt) begin
        if (hold_full) begin
          sr_nxt        = hold;
          hold_full_nxt = 1'b0;
        end else begin
          sr_nxt       = '0;
          underrun_nxt = 1'b1;
        end
      end else begin
        sr_nxt = {sr[SAMPLE_W-2:0], 1'b0};
      end
    end

    // Only possible with the buffer empty, so it never collides with a consume.
    if (xfer) begin
      hold_nxt      = x;
      hold_full_nxt = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge c) begin
    if (r) begin
      div_cnt   <= '0;
      bit_idx   <= LAST_IDX;
      sr        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bclk      <= 1'b0;
      lrclk     <= 1'b1;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt   <= div_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      sr        <= sr_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      bclk      <= bclk_nxt;
      lrclk     <= lrclk_nxt;
      sdata     <= sdata_nxt;
      underrun  <= underrun_nxt;
    end
  end

endmodule
